// File: rtl/mem_issue_pipe_pkg.sv
// Shared core types for the memory issue path: physical register / ROB indices,
// the issued-entry payload and the ROB age compare used by squash logic.
package mem_issue_pipe_pkg;

    localparam int XLEN     = 64;
    localparam int IPR_W    = 7;
    localparam int ROB_W    = 6;
    localparam int IQ_IDX_W = 3;
    localparam int LSQ_W    = 5;
    localparam int MICOP_W  = 4;

    typedef logic [IPR_W-1:0] iprIdx_t;

    typedef struct packed {
        logic             flag;
        logic [ROB_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        iprIdx_t [1:0]       iprs;
        iprIdx_t             iprd;
        robIdx_t             robIdx;
        logic [IQ_IDX_W-1:0] iqIdx;
        logic                useImm;
        logic [MICOP_W-1:0]  micOp;
        logic [LSQ_W-1:0]    lqIdx;
        logic [LSQ_W-1:0]    sqIdx;
    } issueState_t;

    // The flag bit flips on every ROB wrap, so differing flags invert the index order.
    function automatic logic rob_is_older(robIdx_t a, robIdx_t b);
        return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/mem_issue_slot.sv
// One issue port: i1 register-file read request and capture, i2 operand
// assembly, cancel/squash checks and success/replay feedback to the IQ.
module mem_issue_slot
    import mem_issue_pipe_pkg::*;
#(
    parameter int WK_NUM = 2,
    parameter int FB_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    can_issue,
    input  issueState_t             state,
    input  logic [XLEN-1:0]         imm,
    input  logic [WK_NUM-1:0]       cancel_vec,
    input  iprIdx_t [WK_NUM-1:0]    cancel_iprd,
    input  logic                    squash_vld,
    input  robIdx_t                 squash_rob,
    input  logic                    fu_ready,
    input  logic [1:0][XLEN-1:0]    rf_rdata,
    output logic [1:0]              rf_rd_vld,
    output iprIdx_t [1:0]           rf_rd_idx,
    output logic                    fu_vld,
    output issueState_t             fu_state,
    output logic [1:0][XLEN-1:0]    fu_src,
    output logic                    success,
    output logic                    replay,
    output logic                    replay_cancel,
    output logic [FB_W-1:0]         feedback_idx
);

    function automatic logic src_hit(issueState_t s, logic [WK_NUM-1:0] vec,
                                     iprIdx_t [WK_NUM-1:0] iprd);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WK_NUM; w++) begin
            if (vec[w] && (s.iprs[0] == iprd[w] || (!s.useImm && s.iprs[1] == iprd[w])))
                hit = 1'b1;
        end
        return hit;
    endfunction

    logic            i2_vld;
    logic            i2_sticky;
    issueState_t     i2_state;
    logic [XLEN-1:0] i2_imm;

    logic i1_hit, i1_kill, capture;
    logic i2_hit, i2_kill, i2_cancel, live;

    assign rf_rd_vld[0] = can_issue;
    assign rf_rd_vld[1] = can_issue && !state.useImm;
    assign rf_rd_idx    = state.iprs;

    assign i1_hit  = src_hit(state, cancel_vec, cancel_iprd);
    assign i1_kill = squash_vld && !rob_is_older(state.robIdx, squash_rob);
    assign capture = can_issue && !i1_kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2_vld    <= 1'b0;
            i2_sticky <= 1'b0;
            i2_state  <= '0;
            i2_imm    <= '0;
        end else begin
            i2_vld <= capture;
            if (capture) begin
                i2_sticky <= i1_hit;
                i2_state  <= state;
                i2_imm    <= imm;
            end
        end
    end

    assign i2_hit    = src_hit(i2_state, cancel_vec, cancel_iprd);
    assign i2_cancel = i2_sticky || i2_hit;
    assign i2_kill   = squash_vld && !rob_is_older(i2_state.robIdx, squash_rob);
    assign live      = i2_vld && !i2_kill;

    // Handshake to the LSU: fu_vld is raised only in a cycle where fu_ready is
    // already high, so the op is accepted on that edge; a not-ready port is
    // never stalled, its entry goes back to the IQ as a replay instead.
    assign success       = live && !i2_cancel && fu_ready;
    assign replay        = live && (i2_cancel || !fu_ready);
    assign replay_cancel = replay && i2_cancel;
    assign fu_vld        = success;
    assign fu_state      = i2_state;
    assign fu_src[0]     = success ? rf_rdata[0] : '0;
    assign fu_src[1]     = success ? (i2_state.useImm ? i2_imm : rf_rdata[1]) : '0;
    assign feedback_idx  = (success || replay) ? FB_W'(i2_state.iqIdx) : '0;

endmodule

// File: rtl/mem_issue_pipe.sv
// Memory issue pipeline (i1/i2) between the memory IQ and the LDU/STU.
// Optional MEM_ISSUE_PERF_EN adds saturating issue/replay/cancel counters.
module mem_issue_pipe
    import mem_issue_pipe_pkg::*;
#(
    parameter int PORT_NUM = 2,
    parameter int WK_NUM   = 2,
    parameter int IQ_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [PORT_NUM-1:0]                    i_can_issue,
    input  issueState_t [PORT_NUM-1:0]             i_issueState,
    output logic [PORT_NUM*2-1:0]                  o_rf_rd_vld,
    output iprIdx_t [PORT_NUM*2-1:0]               o_rf_rd_idx,
    input  logic [PORT_NUM*2-1:0][XLEN-1:0]        i_rf_rdata,
    input  logic [PORT_NUM-1:0][XLEN-1:0]          i_imm,
    input  logic [WK_NUM-1:0]                      i_src_cancel_vec,
    input  iprIdx_t [WK_NUM-1:0]                   i_src_cancel_iprd,
    input  logic                                   i_squash_vld,
    input  robIdx_t                                i_squash_robIdx,
    input  logic [PORT_NUM-1:0]                    i_fu_ready,
    output logic [PORT_NUM-1:0]                    o_fu_busy,
    output logic [PORT_NUM-1:0]                    o_fu_vld,
    output issueState_t [PORT_NUM-1:0]             o_fu_state,
    output logic [PORT_NUM*2-1:0][XLEN-1:0]        o_fu_src,
    output logic [PORT_NUM-1:0]                    o_issueSuccess,
    output logic [PORT_NUM-1:0]                    o_issueReplay,
    output logic [PORT_NUM-1:0][$clog2(IQ_DEPTH)-1:0] o_feedbackIdx
`ifdef MEM_ISSUE_PERF_EN
    ,
    output logic [31:0]                            o_perf_issue_cnt,
    output logic [31:0]                            o_perf_replay_cnt,
    output logic [31:0]                            o_perf_cancel_cnt
`endif
);

    logic [PORT_NUM-1:0] replay_cancel;

    assign o_fu_busy = ~i_fu_ready;

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_slot
        mem_issue_slot #(
            .WK_NUM (WK_NUM),
            .FB_W   ($clog2(IQ_DEPTH))
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .can_issue     (i_can_issue[p]),
            .state         (i_issueState[p]),
            .imm           (i_imm[p]),
            .cancel_vec    (i_src_cancel_vec),
            .cancel_iprd   (i_src_cancel_iprd),
            .squash_vld    (i_squash_vld),
            .squash_rob    (i_squash_robIdx),
            .fu_ready      (i_fu_ready[p]),
            .rf_rdata      (i_rf_rdata[2*p +: 2]),
            .rf_rd_vld     (o_rf_rd_vld[2*p +: 2]),
            .rf_rd_idx     (o_rf_rd_idx[2*p +: 2]),
            .fu_vld        (o_fu_vld[p]),
            .fu_state      (o_fu_state[p]),
            .fu_src        (o_fu_src[2*p +: 2]),
            .success       (o_issueSuccess[p]),
            .replay        (o_issueReplay[p]),
            .replay_cancel (replay_cancel[p]),
            .feedback_idx  (o_feedbackIdx[p])
        );
    end

`ifdef MEM_ISSUE_PERF_EN
    function automatic logic [31:0] sat_add(logic [31:0] cnt, logic [PORT_NUM-1:0] pulses);
        logic [32:0] sum;
        sum = {1'b0, cnt} + 33'($countones(pulses));
        return sum[32] ? '1 : sum[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_perf_issue_cnt  <= '0;
            o_perf_replay_cnt <= '0;
            o_perf_cancel_cnt <= '0;
        end else begin
            o_perf_issue_cnt  <= sat_add(o_perf_issue_cnt, o_issueSuccess);
            o_perf_replay_cnt <= sat_add(o_perf_replay_cnt, o_issueReplay);
            o_perf_cancel_cnt <= sat_add(o_perf_cancel_cnt, replay_cancel);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = ^replay_cancel;
`endif

endmodule

// File: tb/tb_mem_issue_pipe.sv
// Directed bench for mem_issue_pipe with an expected-result queue per i2 cycle.
module tb_mem_issue_pipe;
    import mem_issue_pipe_pkg::*;

    localparam int PORT_NUM = 2;
    localparam int WK_NUM   = 2;
    localparam int IQ_DEPTH = 8;
    localparam int W        = 3 + 3 + 2*XLEN;
    localparam int CW       = 192;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [PORT_NUM-1:0]              i_can_issue;
    issueState_t [PORT_NUM-1:0]       i_issueState;
    logic [PORT_NUM*2-1:0]            o_rf_rd_vld;
    iprIdx_t [PORT_NUM*2-1:0]         o_rf_rd_idx;
    logic [PORT_NUM*2-1:0][XLEN-1:0]  i_rf_rdata;
    logic [PORT_NUM-1:0][XLEN-1:0]    i_imm;
    logic [WK_NUM-1:0]                i_src_cancel_vec;
    iprIdx_t [WK_NUM-1:0]             i_src_cancel_iprd;
    logic                             i_squash_vld;
    robIdx_t                          i_squash_robIdx;
    logic [PORT_NUM-1:0]              i_fu_ready;
    logic [PORT_NUM-1:0]              o_fu_busy;
    logic [PORT_NUM-1:0]              o_fu_vld;
    issueState_t [PORT_NUM-1:0]       o_fu_state;
    logic [PORT_NUM*2-1:0][XLEN-1:0]  o_fu_src;
    logic [PORT_NUM-1:0]              o_issueSuccess;
    logic [PORT_NUM-1:0]              o_issueReplay;
    logic [PORT_NUM-1:0][2:0]         o_feedbackIdx;
`ifdef MEM_ISSUE_PERF_EN
    logic [31:0] o_perf_issue_cnt, o_perf_replay_cnt, o_perf_cancel_cnt;
`endif

    mem_issue_pipe #(.PORT_NUM(PORT_NUM), .WK_NUM(WK_NUM), .IQ_DEPTH(IQ_DEPTH)) dut (
        .clk (clk), .rst (rst),
        .i_can_issue (i_can_issue), .i_issueState (i_issueState),
        .o_rf_rd_vld (o_rf_rd_vld), .o_rf_rd_idx (o_rf_rd_idx),
        .i_rf_rdata (i_rf_rdata), .i_imm (i_imm),
        .i_src_cancel_vec (i_src_cancel_vec), .i_src_cancel_iprd (i_src_cancel_iprd),
        .i_squash_vld (i_squash_vld), .i_squash_robIdx (i_squash_robIdx),
        .i_fu_ready (i_fu_ready), .o_fu_busy (o_fu_busy),
        .o_fu_vld (o_fu_vld), .o_fu_state (o_fu_state), .o_fu_src (o_fu_src),
        .o_issueSuccess (o_issueSuccess), .o_issueReplay (o_issueReplay),
        .o_feedbackIdx (o_feedbackIdx)
`ifdef MEM_ISSUE_PERF_EN
        , .o_perf_issue_cnt (o_perf_issue_cnt), .o_perf_replay_cnt (o_perf_replay_cnt),
        .o_perf_cancel_cnt (o_perf_cancel_cnt)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(logic v, logic s, logic r, logic [2:0] fb,
                                        logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        return {v, s, r, fb, a, b};
    endfunction

    function automatic logic [W-1:0] obs(int p);
        return pk(o_fu_vld[p], o_issueSuccess[p], o_issueReplay[p], o_feedbackIdx[p],
                  o_fu_src[2*p], o_fu_src[2*p+1]);
    endfunction

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // driver tasks
    task automatic idle();
        i_can_issue       = '0;
        i_issueState      = '0;
        i_imm             = '0;
        i_src_cancel_vec  = '0;
        i_src_cancel_iprd = '0;
        i_squash_vld      = 1'b0;
        i_squash_robIdx   = '0;
        i_fu_ready        = '1;
        i_rf_rdata        = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drive_entry(input int p, input logic [6:0] r0, input logic [6:0] r1,
                               input logic rf, input logic [5:0] ri, input logic [2:0] iq,
                               input logic ui, input logic [XLEN-1:0] imm);
        issueState_t s;
        s             = '0;
        s.iprs[0]     = r0;
        s.iprs[1]     = r1;
        s.iprd        = 7'd33;
        s.robIdx.flag = rf;
        s.robIdx.idx  = ri;
        s.iqIdx       = iq;
        s.useImm      = ui;
        s.micOp       = 4'd3;
        s.lqIdx       = 5'd9;
        s.sqIdx       = 5'd2;
        i_issueState[p] = s;
        i_can_issue[p]  = 1'b1;
        i_imm[p]        = imm;
    endtask

    // scoreboard: one queued expectation per port per i2 cycle
    task automatic check_i2(input string tag);
        @(negedge clk);
        for (int p = 0; p < PORT_NUM; p++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_p%0d got=output exp=none_queued", tag, p);
            end else begin
                check($sformatf("%s_p%0d", tag, p), CW'(obs(p)), CW'(exp_q.pop_front()));
            end
        end
    endtask

    logic [XLEN-1:0] ra, rb, rc, rd;
    logic [2:0]      piq [PORT_NUM];
    logic [2:0]      iq;

    initial begin
        idle();
        rst = 1'b0;
        i_fu_ready = 2'b01;
        #12;
        check("rst_outputs", CW'({o_fu_vld, o_issueSuccess, o_issueReplay, o_feedbackIdx, o_fu_src}), '0);
        check("rst_busy", CW'(o_fu_busy), CW'(2'b10));
`ifdef MEM_ISSUE_PERF_EN
        check("rst_perf", CW'({o_perf_issue_cnt, o_perf_replay_cnt, o_perf_cancel_cnt}), '0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // basic issue on port0
        next_cycle();
        drive_entry(0, 7'd5, 7'd7, 1'b0, 6'd1, 3'd3, 1'b0, '0);
        @(negedge clk);
        check("basic_rd_vld", CW'(o_rf_rd_vld), CW'(4'b0011));
        check("basic_rd_idx", CW'({o_rf_rd_idx[1], o_rf_rd_idx[0]}), CW'({7'd7, 7'd5}));
        next_cycle();
        ra = 64'h1111_2222_3333_4444;
        rb = 64'h5555_6666_7777_8888;
        i_rf_rdata[0] = ra;
        i_rf_rdata[1] = rb;
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd3, ra, rb));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("basic");
        check("basic_state_iq", CW'(o_fu_state[0].iqIdx), CW'(3'd3));
        check("basic_state_rob", CW'(o_fu_state[0].robIdx), CW'({1'b0, 6'd1}));

        // immediate operand on port1
        next_cycle();
        drive_entry(1, 7'd4, 7'd9, 1'b0, 6'd2, 3'd5, 1'b1, 64'h40);
        @(negedge clk);
        check("imm_rd_vld", CW'(o_rf_rd_vld), CW'(4'b0100));
        check("imm_rd_idx", CW'(o_rf_rd_idx[2]), CW'(7'd4));
        next_cycle();
        rc = rnd64();
        i_rf_rdata[2] = rc;
        i_rf_rdata[3] = rnd64();
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd5, rc, 64'h40));
        check_i2("imm");

        // cancel while in i1 (only wakeup source 1 active)
        next_cycle();
        drive_entry(0, 7'd5, 7'd7, 1'b0, 6'd3, 3'd2, 1'b0, '0);
        i_src_cancel_vec     = 2'b10;
        i_src_cancel_iprd[0] = 7'd7;
        i_src_cancel_iprd[1] = 7'd5;
        next_cycle();
        i_rf_rdata[0] = rnd64();
        exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 3'd2, '0, '0));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("cancel_i1");

        // cancel arriving only in i2
        next_cycle();
        drive_entry(0, 7'd5, 7'd7, 1'b0, 6'd3, 3'd4, 1'b0, '0);
        next_cycle();
        i_src_cancel_vec     = 2'b01;
        i_src_cancel_iprd[0] = 7'd7;
        exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 3'd4, '0, '0));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("cancel_i2");

        // cancel on iprs[1] is ignored when the immediate replaces it
        next_cycle();
        drive_entry(0, 7'd6, 7'd5, 1'b0, 6'd3, 3'd1, 1'b1, 64'h99);
        i_src_cancel_vec     = 2'b01;
        i_src_cancel_iprd[0] = 7'd5;
        next_cycle();
        i_src_cancel_vec     = 2'b01;
        i_src_cancel_iprd[0] = 7'd5;
        ra = rnd64();
        i_rf_rdata[0] = ra;
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd1, ra, 64'h99));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("cancel_imm");

        // backpressure on port1 only
        next_cycle();
        drive_entry(0, 7'd10, 7'd11, 1'b0, 6'd4, 3'd6, 1'b0, '0);
        drive_entry(1, 7'd12, 7'd13, 1'b0, 6'd5, 3'd7, 1'b0, '0);
        next_cycle();
        i_fu_ready = 2'b01;
        ra = rnd64(); rb = rnd64();
        i_rf_rdata[0] = ra; i_rf_rdata[1] = rb;
        i_rf_rdata[2] = rnd64(); i_rf_rdata[3] = rnd64();
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd6, ra, rb));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 3'd7, '0, '0));
        check_i2("bp");
        check("bp_busy", CW'(o_fu_busy), CW'(2'b10));

        // squash in i2: younger killed, older survives
        next_cycle();
        drive_entry(0, 7'd1, 7'd2, 1'b0, 6'd10, 3'd1, 1'b0, '0);
        drive_entry(1, 7'd3, 7'd4, 1'b0, 6'd6, 3'd2, 1'b0, '0);
        next_cycle();
        i_squash_vld = 1'b1;
        i_squash_robIdx = '{flag: 1'b0, idx: 6'd8};
        rc = rnd64(); rd = rnd64();
        i_rf_rdata[2] = rc; i_rf_rdata[3] = rd;
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd2, rc, rd));
        check_i2("squash");

        // squash across the wrap; equal robIdx is killed
        next_cycle();
        drive_entry(0, 7'd1, 7'd2, 1'b0, 6'd12, 3'd3, 1'b0, '0);
        drive_entry(1, 7'd3, 7'd4, 1'b1, 6'd2, 3'd4, 1'b0, '0);
        next_cycle();
        i_squash_vld = 1'b1;
        i_squash_robIdx = '{flag: 1'b1, idx: 6'd2};
        ra = rnd64(); rb = rnd64();
        i_rf_rdata[0] = ra; i_rf_rdata[1] = rb;
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd3, ra, rb));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("squash_wrap");

        // squash while in i1: younger entry never reaches i2
        next_cycle();
        drive_entry(0, 7'd1, 7'd2, 1'b0, 6'd9, 3'd5, 1'b0, '0);
        drive_entry(1, 7'd3, 7'd4, 1'b0, 6'd7, 3'd6, 1'b0, '0);
        i_squash_vld = 1'b1;
        i_squash_robIdx = '{flag: 1'b0, idx: 6'd8};
        next_cycle();
        rc = rnd64(); rd = rnd64();
        i_rf_rdata[2] = rc; i_rf_rdata[3] = rd;
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd6, rc, rd));
        check_i2("squash_i1");

        // back-to-back issue on both ports every cycle
        for (int i = 0; i <= 5; i++) begin
            next_cycle();
            if (i > 0) begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    ra = rnd64(); rb = rnd64();
                    i_rf_rdata[2*p]   = ra;
                    i_rf_rdata[2*p+1] = rb;
                    exp_q.push_back(pk(1'b1, 1'b1, 1'b0, piq[p], ra, rb));
                end
            end
            if (i < 5) begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    iq = 3'($urandom_range(0, 7));
                    piq[p] = iq;
                    drive_entry(p, 7'(10 + i), 7'(20 + i), 1'b0, 6'(i), iq, 1'b0, '0);
                end
            end
            if (i > 0) check_i2($sformatf("b2b%0d", i));
        end

        // asynchronous reset with both i2 slots occupied
        next_cycle();
        drive_entry(0, 7'd1, 7'd2, 1'b0, 6'd1, 3'd1, 1'b0, '0);
        drive_entry(1, 7'd3, 7'd4, 1'b0, 6'd2, 3'd2, 1'b0, '0);
        next_cycle();
        i_rf_rdata[0] = rnd64();
        i_rf_rdata[2] = rnd64();
        #1;
        rst = 1'b0;
        #1;
        check("midrst_outputs", CW'({o_fu_vld, o_issueSuccess, o_issueReplay, o_feedbackIdx, o_fu_src}), '0);
`ifdef MEM_ISSUE_PERF_EN
        check("midrst_perf", CW'({o_perf_issue_cnt, o_perf_replay_cnt, o_perf_cancel_cnt}), '0);
`endif
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("post_rst");

        // three successes and one backpressure replay
        next_cycle();
        drive_entry(0, 7'd1, 7'd2, 1'b0, 6'd1, 3'd0, 1'b0, '0);
        drive_entry(1, 7'd3, 7'd4, 1'b0, 6'd2, 3'd1, 1'b0, '0);
        next_cycle();
        ra = rnd64(); rb = rnd64(); rc = rnd64(); rd = rnd64();
        i_rf_rdata[0] = ra; i_rf_rdata[1] = rb; i_rf_rdata[2] = rc; i_rf_rdata[3] = rd;
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd0, ra, rb));
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd1, rc, rd));
        check_i2("cnt_a");
        next_cycle();
        drive_entry(0, 7'd1, 7'd2, 1'b0, 6'd3, 3'd2, 1'b0, '0);
        next_cycle();
        i_fu_ready = 2'b10;
        exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 3'd2, '0, '0));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("cnt_b");
        next_cycle();
        drive_entry(1, 7'd3, 7'd4, 1'b0, 6'd4, 3'd3, 1'b0, '0);
        next_cycle();
        rc = rnd64(); rd = rnd64();
        i_rf_rdata[2] = rc; i_rf_rdata[3] = rd;
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd3, rc, rd));
        check_i2("cnt_c");
        next_cycle();
`ifdef MEM_ISSUE_PERF_EN
        check("perf_issue", CW'(o_perf_issue_cnt), CW'(32'd3));
        check("perf_replay", CW'(o_perf_replay_cnt), CW'(32'd1));
        check("perf_cancel", CW'(o_perf_cancel_cnt), CW'(32'd0));
`endif

        // one cancel-caused replay
        drive_entry(0, 7'd8, 7'd9, 1'b0, 6'd5, 3'd4, 1'b0, '0);
        i_src_cancel_vec     = 2'b01;
        i_src_cancel_iprd[0] = 7'd9;
        next_cycle();
        exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 3'd4, '0, '0));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, '0, '0));
        check_i2("cnt_d");
        next_cycle();
`ifdef MEM_ISSUE_PERF_EN
        check("perf_issue2", CW'(o_perf_issue_cnt), CW'(32'd3));
        check("perf_replay2", CW'(o_perf_replay_cnt), CW'(32'd2));
        check("perf_cancel2", CW'(o_perf_cancel_cnt), CW'(32'd1));
`endif

        check("queue_drained", CW'(exp_q.size()), CW'(0));

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
